// File: rtl/skew_align_fifo.sv
// Synchronous FIFO used by skew_align for each input stream.
// Read data is registered and holds its value when no pop occurs.
module align_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]  fill,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned FILL_WIDTH = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FILL_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  push, pop;

  assign full  = (fill_q == FILL_WIDTH'(DEPTH));
  assign empty = (fill_q == '0);

  // A full FIFO still accepts a write when a read frees the slot in the same cycle.
  assign push = wr_en && (!full || rd_en);
  assign pop  = rd_en && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    rd_data_d = rd_data_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    if (push && !pop)      fill_d = fill_q + FILL_WIDTH'(1);
    else if (pop && !push) fill_d = fill_q - FILL_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign fill    = fill_q;

endmodule

// File: rtl/skew_align.sv
// Re-aligns two valid-qualified streams with unknown relative delay by
// buffering each in a FIFO and releasing pairs only when both hold data.
module skew_align #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   a_data,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   b_data,
  input  logic                    b_valid,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    dout_valid,
  output logic [$clog2(DEPTH):0]  fill_a,
  output logic [$clog2(DEPTH):0]  fill_b,
  output logic                    ovf_a,
  output logic                    ovf_b
);

  logic full_a, full_b;
  logic empty_a, empty_b;
  logic pop;
  logic dout_valid_q, dout_valid_d;
  logic ovf_a_q, ovf_a_d;
  logic ovf_b_q, ovf_b_d;

  // Emptiness comes from the registered fill counters, so pop never underflows.
  assign pop = !empty_a && !empty_b;

  align_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (a_valid),
    .wr_data (a_data),
    .rd_en   (pop),
    .rd_data (dout_a),
    .fill    (fill_a),
    .full    (full_a),
    .empty   (empty_a)
  );

  align_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (b_valid),
    .wr_data (b_data),
    .rd_en   (pop),
    .rd_data (dout_b),
    .fill    (fill_b),
    .full    (full_b),
    .empty   (empty_b)
  );

  always_comb begin
    dout_valid_d = pop;
    ovf_a_d      = ovf_a_q || (a_valid && full_a && !pop);
    ovf_b_d      = ovf_b_q || (b_valid && full_b && !pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      ovf_a_q      <= 1'b0;
      ovf_b_q      <= 1'b0;
    end else begin
      dout_valid_q <= dout_valid_d;
      ovf_a_q      <= ovf_a_d;
      ovf_b_q      <= ovf_b_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign ovf_a      = ovf_a_q;
  assign ovf_b      = ovf_b_q;

endmodule

// File: tb/tb_skew_align.sv
// Directed bench for skew_align: per-cycle comparison against a small
// behavioural model with sample queues acting as the pairing scoreboard.
module tb_skew_align;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned FW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [DW-1:0] dout_a, dout_b;
  logic          dout_valid;
  logic [FW-1:0] fill_a, fill_b;
  logic          ovf_a, ovf_b;

  skew_align #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .b_data     (b_data),
    .b_valid    (b_valid),
    .dout_a     (dout_a),
    .dout_b     (dout_b),
    .dout_valid (dout_valid),
    .fill_a     (fill_a),
    .fill_b     (fill_b),
    .ovf_a      (ovf_a),
    .ovf_b      (ovf_b)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          mfa, mfb;
  bit          movfa, movfb, mvalid;
  logic [31:0] mda, mdb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    mfa = 0; mfb = 0;
    movfa = 0; movfb = 0; mvalid = 0;
    mda = '0; mdb = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(dout_valid), 32'(mvalid));
    chk({tag, ".dout_a"}, dout_a, mda);
    chk({tag, ".dout_b"}, dout_b, mdb);
    chk({tag, ".fill_a"}, 32'(fill_a), 32'(mfa));
    chk({tag, ".fill_b"}, 32'(fill_b), 32'(mfb));
    chk({tag, ".ovf_a"}, 32'(ovf_a), 32'(movfa));
    chk({tag, ".ovf_b"}, 32'(ovf_b), 32'(movfb));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input string tag, input bit av, input logic [31:0] ad,
                      input bit bv, input logic [31:0] bd);
    bit pop, fulla, fullb;
    a_valid = av; a_data = ad;
    b_valid = bv; b_data = bd;
    pop   = (mfa != 0) && (mfb != 0);
    fulla = (mfa == DEPTH);
    fullb = (mfb == DEPTH);
    mvalid = pop;
    if (pop) begin
      mda = qa.pop_front();
      mdb = qb.pop_front();
      mfa--; mfb--;
    end
    if (av) begin
      if (!fulla || pop) begin qa.push_back(ad); mfa++; end
      else movfa = 1;
    end
    if (bv) begin
      if (!fullb || pop) begin qb.push_back(bd); mfb++; end
      else movfb = 1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0;
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, '0, 0, '0);
  endtask

  initial begin
    model_clear();
    rst = 1;
    #12;
    chk("reset.valid", 32'(dout_valid), 32'd0);
    chk("reset.dout_a", dout_a, 32'd0);
    chk("reset.fill_a", 32'(fill_a), 32'd0);
    chk("reset.ovf_b", 32'(ovf_b), 32'd0);
    @(negedge clk);
    rst = 0;

    // Aligned streams
    for (int i = 0; i < 8; i++) step("aligned", 1, 32'(i), 1, 32'(100 + i));
    drain("aligned_drain", 3);

    // B lags A by 5 cycles
    do_reset();
    for (int c = 0; c < 15; c++)
      step("lag", c < 10, 32'(1 + c), (c >= 5), 32'(201 + c - 5));
    drain("lag_drain", 8);

    // Gapped valids: A on even cycles, B on odd cycles
    do_reset();
    for (int c = 0; c < 20; c++)
      step("gapped", (c % 2) == 0, 32'(700 + c / 2), (c % 2) == 1, 32'(800 + c / 2));
    drain("gapped_drain", 4);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) step("fill16", 1, 32'(500 + i), 0, '0);
    chk("full.fill_a", 32'(fill_a), 32'd16);
    step("b_one", 0, '0, 1, 32'd600);
    step("pushpop", 1, 32'd516, 1, 32'd601);
    chk("pushpop.fill_a", 32'(fill_a), 32'd16);
    chk("pushpop.ovf_a", 32'(ovf_a), 32'd0);
    for (int i = 0; i < 15; i++) step("pushpop_b", 0, '0, 1, 32'(602 + i));
    drain("pushpop_drain", 4);

    // Reset asserted mid-operation with fill_a=7
    do_reset();
    step("pre_pair", 1, 32'h11, 1, 32'h22);
    for (int i = 0; i < 7; i++) step("fill7", 1, 32'(900 + i), 0, '0);
    chk("fill7.fill_a", 32'(fill_a), 32'd7);
    chk("fill7.dout_a", dout_a, 32'h11);
    a_valid = 0; b_valid = 0;
    #3;
    rst = 1;
    #1;
    chk("midrst.dout_a", dout_a, 32'd0);
    chk("midrst.dout_b", dout_b, 32'd0);
    chk("midrst.fill_a", 32'(fill_a), 32'd0);
    chk("midrst.valid", 32'(dout_valid), 32'd0);
    @(negedge clk);
    rst = 0;
    model_clear();
    step("post_rst_in", 1, 32'hAA, 1, 32'hBB);
    chk("post_rst_in.valid", 32'(dout_valid), 32'd0);
    step("post_rst_out", 0, '0, 0, '0);
    chk("post_rst_out.valid", 32'(dout_valid), 32'd1);
    chk("post_rst_out.dout_a", dout_a, 32'hAA);
    chk("post_rst_out.dout_b", dout_b, 32'hBB);

    // Overflow: A sends 20 with B idle, then B sends 16
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step("ovf_fill", 1, 32'(300 + i), 0, '0);
      if (i == 16) begin
        chk("ovf17.fill_a", 32'(fill_a), 32'd16);
        chk("ovf17.ovf_a", 32'(ovf_a), 32'd1);
        chk("ovf17.ovf_b", 32'(ovf_b), 32'd0);
      end
    end
    for (int i = 0; i < 16; i++) step("ovf_b_send", 0, '0, 1, 32'(400 + i));
    drain("ovf_drain", 4);
    chk("ovf_end.dout_a", dout_a, 32'd315);
    chk("ovf_end.dout_b", dout_b, 32'd415);
    chk("ovf_end.ovf_a", 32'(ovf_a), 32'd1);
    chk("scoreboard_empty", 32'(qa.size() + qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
